// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with a single registered output stage.
// Channel selection is round-robin or fixed priority (channel 0 highest), chosen per cycle.
module rr_stream_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic                     prio_mode,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic              out_valid_q, out_valid_d;

    logic              load;
    logic              xfer;
    logic              gnt_vld;
    logic [CH_W-1:0]   gnt_ch;
    logic [NUM_CH-1:0] gnt_oh;
    logic [DATA_W-1:0] gnt_data;

    assign load = !out_valid_q || out_ready;

    // Rotating scan without modulo: pass 0 only looks at channels at or above
    // rr_ptr (all channels in fixed mode), pass 1 wraps around to the rest.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_ch   = '0;
        gnt_oh   = '0;
        gnt_data = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (!gnt_vld && in_valid[i] &&
                    (p == 1 || prio_mode || i >= 32'(rr_ptr_q))) begin
                    gnt_vld   = 1'b1;
                    gnt_ch    = CH_W'(i);
                    gnt_oh[i] = 1'b1;
                    gnt_data  = in_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // rst_n gates the handshake so no transfer is offered while reset is held.
    assign xfer     = rst_n && load && gnt_vld;
    assign in_ready = xfer ? gnt_oh : '0;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_valid_d = gnt_vld;
        end
        if (xfer) begin
            out_data_d = gnt_data;
            out_ch_d   = gnt_ch;
            if (!prio_mode) begin
                rr_ptr_d = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed self-checking bench for rr_stream_mux (NUM_CH=4, DATA_W=8).
// Channel data AA, BB, CC, DD on channels 0..3.
module tb_rr_stream_mux;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int CH_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic                     prio_mode;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_valid;
    logic                     out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ch_byte [4];

    rr_stream_mux #(
        .NUM_CH(NUM_CH),
        .DATA_W(DATA_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .prio_mode(prio_mode),
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'(v));
        check_eq({tag, ".data"},  32'(out_data),  32'(d));
        check_eq({tag, ".ch"},    32'(out_ch),    32'(c));
    endtask

    initial begin
        ch_byte[0] = 8'hAA;
        ch_byte[1] = 8'hBB;
        ch_byte[2] = 8'hCC;
        ch_byte[3] = 8'hDD;
        in_data   = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        in_valid  = 4'b0000;
        prio_mode = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_eq("rst.in_ready_low", 32'(in_ready), 32'h0);
        in_valid = 4'b1111;
        #1;
        check_eq("rst.in_ready_gated", 32'(in_ready), 32'h0);
        tick();
        tick();
        check_out("rst.held", 1'b0, 8'h00, 2'd0);
        rst_n    = 1'b1;
        in_valid = 4'b0000;
        #1;
        check_out("rst.released", 1'b0, 8'h00, 2'd0);
        check_eq("rst.in_ready_idle", 32'(in_ready), 32'h0);

        // Round-robin sweep: two full rotations, no bubbles.
        prio_mode = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        check_eq("rr.first_ready", 32'(in_ready), 32'b0001);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_out($sformatf("rr.sweep%0d", k), 1'b1, ch_byte[k % 4], 2'(k % 4));
        end

        // Fixed priority with channel 0 idle: channel 1 wins every cycle.
        prio_mode = 1'b1;
        in_valid  = 4'b1110;
        #1;
        check_eq("fp.ready", 32'(in_ready), 32'b0010);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out($sformatf("fp.cyc%0d", k), 1'b1, 8'hBB, 2'd1);
            check_eq($sformatf("fp.ready%0d", k), 32'(in_ready), 32'b0010);
        end

        // Backpressure: load CC (rr_ptr 0 -> 3) then hold it.
        prio_mode = 1'b0;
        in_valid  = 4'b0100;
        #1;
        check_eq("bp.load_ready", 32'(in_ready), 32'b0100);
        tick();
        check_out("bp.loaded", 1'b1, 8'hCC, 2'd2);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        #1;
        check_eq("bp.no_ready", 32'(in_ready), 32'h0);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) in_data[23:16] = 8'h5A;
            tick();
            check_out($sformatf("bp.hold%0d", k), 1'b1, 8'hCC, 2'd2);
            check_eq($sformatf("bp.ready%0d", k), 32'(in_ready), 32'h0);
        end
        in_data[23:16] = 8'hCC;
        out_ready = 1'b1;
        #1;
        check_eq("bp.release_ready", 32'(in_ready), 32'b1000);
        tick();
        check_out("bp.next", 1'b1, 8'hDD, 2'd3);

        // Wrap with sparse requests: get rr_ptr to 3 first.
        in_valid = 4'b0100;
        tick();
        check_out("wrap.setup", 1'b1, 8'hCC, 2'd2);
        in_valid = 4'b0011;
        #1;
        check_eq("wrap.ready0", 32'(in_ready), 32'b0001);
        tick();
        check_out("wrap.g0", 1'b1, 8'hAA, 2'd0);
        tick();
        check_out("wrap.g1", 1'b1, 8'hBB, 2'd1);
        tick();
        check_out("wrap.g2", 1'b1, 8'hAA, 2'd0);

        // Idle: valid drops, data/channel hold. rr_ptr is 1 here.
        in_valid = 4'b0000;
        #1;
        check_eq("idle.ready", 32'(in_ready), 32'h0);
        tick();
        check_out("idle.drop", 1'b0, 8'hAA, 2'd0);

        // Mode switch: rr from ptr=1 picks ch3, then move ptr to 2.
        in_valid = 4'b1001;
        #1;
        check_eq("ms.rr_ready", 32'(in_ready), 32'b1000);
        tick();
        check_out("ms.rr", 1'b1, 8'hDD, 2'd3);
        in_valid = 4'b0010;
        tick();
        check_out("ms.ptr2", 1'b1, 8'hBB, 2'd1);
        prio_mode = 1'b1;
        in_valid  = 4'b1001;
        #1;
        check_eq("ms.fp_ready", 32'(in_ready), 32'b0001);
        tick();
        check_out("ms.fp", 1'b1, 8'hAA, 2'd0);
        // Fixed-mode transfer left rr_ptr at 2, so rr now picks ch3.
        prio_mode = 1'b0;
        #1;
        check_eq("ms.ptr_kept", 32'(in_ready), 32'b1000);
        tick();
        check_out("ms.back_rr", 1'b1, 8'hDD, 2'd3);

        // Asynchronous reset mid-cycle with a word held under backpressure.
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        tick();
        check_out("ar.before", 1'b1, 8'hDD, 2'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("ar.immediate", 1'b0, 8'h00, 2'd0);
        check_eq("ar.in_ready", 32'(in_ready), 32'h0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check_eq("ar.first_ready", 32'(in_ready), 32'b0001);
        tick();
        check_out("ar.first_grant", 1'b1, 8'hAA, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-channel streaming multiplexer with one registered output stage.
- Per-channel valid/ready handshake; output uses valid/ready with backpressure.
- Built-in arbiter selects the channel: round-robin or fixed priority, chosen at run time.
- Sits between several producer streams and one shared consumer. Replaces ad-hoc combinational select-driven muxes where the select source must be arbitrated and flow-controlled.

Parameters:
- NUM_CH, 4, number of input channels (>= 2).
- DATA_W, 8, data width per channel in bits (>= 1).
- CH_W, $clog2(NUM_CH), width of channel index (derived; do not override).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_data  input  NUM_CH*DATA_W  packed channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready (one-hot or zero).
- prio_mode  input  1  0 = round-robin, 1 = fixed priority (channel 0 highest).
- out_data  output  DATA_W  registered selected data.
- out_ch  output  CH_W  index of the channel that supplied out_data.
- out_valid  output  1  output holds a valid word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Interface decided: one clock; reset is asynchronous and active-low.
- Reset values:
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer rr_ptr=0.
  - in_ready=0 while rst_n=0.
- Reset mid-operation: any held output word is discarded, with no handshake. After release, the first grant uses rr_ptr=0.
- load = !out_valid || out_ready. The output register may accept a new word only when load=1.
- Arbitration (combinational, evaluated every cycle):
  - Round-robin: grant the first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping mod NUM_CH.
  - Fixed priority: grant the lowest i with in_valid[i]=1.
  - No valid input: no grant.
- in_ready[g] = load && grant[g]. At most one in_ready bit is high per cycle.
  - in_ready may depend combinationally on in_valid and out_ready.
  - Producers must not make in_valid depend on in_ready.
- Input transfer on channel g: in_valid[g] && in_ready[g] at a clock edge. Next cycle: out_data = channel g data, out_ch = g, out_valid = 1.
- When load=1 and no grant: out_valid goes to 0 next cycle; out_data/out_ch hold their last values.
- When load=0 (out_valid=1, out_ready=0): out_data, out_ch and out_valid hold stable. No in_ready is asserted.
- Latency is 1 cycle from input transfer to out_valid. Throughput is 1 word/cycle when out_ready=1 continuously.
- rr_ptr updates only on an input transfer while prio_mode=0: rr_ptr = (g == NUM_CH-1) ? 0 : g+1.
  - Fixed-mode transfers leave rr_ptr unchanged.
  - prio_mode may change on any cycle; it takes effect for that cycle's arbitration.
- Simultaneous out_ready and a new grant: the old word leaves and the new word loads on the same edge, with no bubble.
- Channel data is sampled only at its own transfer edge. Changes to in_data on non-granted channels have no effect.
- No data loss or duplication: every input transfer produces exactly one output transfer, in grant order.

Test Plan (NUM_CH=4, DATA_W=8, ch0..3 data = AA, BB, CC, DD):
- Reset: assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid=0, out_data=00, out_ch=0, in_ready=0000 immediately, without waiting for a clock edge.
- Round-robin sweep: prio_mode=0, all in_valid=1111, out_ready=1 for 8 cycles -> out_data sequence AA, BB, CC, DD, AA, BB, CC, DD with out_ch 0, 1, 2, 3, 0, 1, 2, 3 and out_valid high every cycle after the first.
- Fixed priority: prio_mode=1, in_valid=1110, out_ready=1 for 3 cycles -> out_data BB each cycle, out_ch=1, in_ready=0010.
- Backpressure: one word CC held with out_ready=0 for 5 cycles while in_valid=1111 -> out_data stays CC, out_ch=2, in_ready=0000. Raise out_ready -> the next word is DD (rr_ptr=3) on the following cycle.
- Wrap and sparse requests: prio_mode=0, rr_ptr=3, in_valid=0011 -> grant ch0 (AA), then ch1 (BB), then ch0.
- Idle and mode switch: in_valid=0000 -> out_valid drops after the consumed word. Switching prio_mode mid-stream from 0 to 1 with in_valid=1001 -> next grant is ch0 regardless of rr_ptr.
